ram_scan_ctrl: RTL and testbench
================================

# ram_scan_ctrl

Parametrised single-clock memory block with one write port and one read port. It clears itself after reset and has an auto-scan read mode that steps through every address on a programmable interval. It generalises the fixed 32x4 switch-driven RAM used on the DE1-SoC board labs. It sits between board I/O (switches, keys, HEX/LEDR drivers) and storage, so a display stage can show either a user-selected word or a rolling dump of the whole memory.

## Interface
Parameters:
- DATA_W, 4: word width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W words.
- SCAN_DIV, 50_000_000: clock cycles per scan step (1 s at 50 MHz); must be ≥1.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset; 0 = skip the clear (memory contents undefined).

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- wr_en, in, 1: write strobe; one word is written per cycle while it is high.
- wr_addr, in, ADDR_W: write address.
- wr_data, in, DATA_W: write data.
- rd_addr, in, ADDR_W: manual read address, used when scan_en=0.
- scan_en, in, 1: 1 = read address comes from the internal scan counter.
- rd_data, out, DATA_W: registered read data.
- rd_addr_q, out, ADDR_W: address that produced the current rd_data; registered and aligned with rd_data.
- busy, out, 1: high while the post-reset clear is in progress.

## Operation
- Storage: DEPTH × DATA_W array, inferable as block RAM or registers.
- State machine has two states:
  - CLEAR (busy=1): each cycle writes 0 to mem[clr_addr]. At clr_addr==DEPTH-1 it moves to RUN; otherwise clr_addr increments.
  - RUN (busy=0): normal operation.
- Reset entry: CLEAR if CLEAR_ON_RESET=1, otherwise RUN.
- During CLEAR:
  - wr_en is ignored; dropped writes are not queued.
  - rd_data is forced to 0 and rd_addr_q holds 0.
- Write (RUN): when wr_en=1, mem[wr_addr] ← wr_data at the clock edge.
- Effective read address: eff_addr = scan_en ? scan_addr : rd_addr.
- Read (RUN): rd_data ← mem[eff_addr] and rd_addr_q ← eff_addr each cycle.
- Read-during-write to the same address is write-first: rd_data returns the new wr_data.
- Scan mode:
  - div_cnt counts 0..SCAN_DIV-1 while scan_en=1.
  - When div_cnt==SCAN_DIV-1, div_cnt wraps to 0 and scan_addr increments.
  - scan_addr wraps from DEPTH-1 to 0 using natural ADDR_W-bit overflow.
- When scan_en=0: div_cnt is cleared to 0 and scan_addr holds its value. Re-enabling scan resumes from the held address with a full SCAN_DIV interval.
- scan_en is ignored during CLEAR; div_cnt and scan_addr stay at 0.
- The write port is independent of scan mode; writes are allowed while scanning.

## Timing
- Reset values (any edge with reset_n=0):
  - rd_data=0, rd_addr_q=0, scan_addr=0, div_cnt=0, clr_addr=0.
  - busy=CLEAR_ON_RESET.
  - Memory contents are untouched by reset itself.
- Clear duration: busy stays high for exactly DEPTH edges after the first edge with reset_n=1, and is low from edge DEPTH+1 onward. The first RUN write is accepted on edge DEPTH+1.
- Read latency: 1 cycle. Address presented before edge k → rd_data/rd_addr_q valid after edge k.
- Write-to-read at a different cycle: a write at edge k is readable at edge k+1, and write-first at edge k itself.
- Scan step: scan_addr changes every SCAN_DIV edges. rd_data reflects the new address one edge later.
- Reset asserted mid-clear or mid-scan: applies at the next edge, and the clear restarts from address 0.
- scan_en toggling on the same edge as a divider terminal count: the scan_en value sampled at that edge wins. If scan_en=0, there is no increment and div_cnt is cleared.
- Worst-case combinational path: eff_addr mux → memory read → rd_data register. No cross-clock paths exist.

## Test plan
Bench parameters: DATA_W=4, ADDR_W=5, SCAN_DIV=4, CLEAR_ON_RESET=1, 10 ns clock.

- **Reset then clear:** reset_n=0 for 2 cycles then 1; write 4'hF to address 3 during the clear. Required: busy=1 for exactly 32 edges; rd_data=0 throughout; after the clear, reading address 3 returns 0 (the write was dropped).
- **Write/read basic:** write 4'hF@0 and 4'hD@1; set rd_addr=0 then 1. Required: rd_data=F then D, each one cycle after the address change; rd_addr_q matches.
- **Read-during-write:** rd_addr=5, wr_en=1, wr_addr=5, wr_data=4'hA on the same edge. Required: rd_data=A after that edge.
- **Scan wrap:** fill mem[i]=i[3:0]; set scan_en=1 for 140 cycles. Required: rd_addr_q steps 0,1,…,31,0,1 every 4 cycles; rd_data=rd_addr_q[3:0].
- **Scan pause/resume:** drop scan_en at scan_addr=7 for 10 cycles, then raise it. Required: rd_addr_q follows rd_addr while paused; after resume, scan shows 7 for 4 cycles, then 8.
- **Reset mid-scan:** pulse reset_n=0 for 1 edge at scan_addr=20. Required: busy=1 again for 32 edges; memory re-cleared to 0; scan restarts at address 0.

Source files
------------

// File: rtl/ram_scan_ctrl.sv
// ram_scan_ctrl: single-clock RAM with one write and one read port.
// After reset it zeroes every word, then serves either a manually selected
// address or an auto-scan address that advances every SCAN_DIV cycles.
module ram_scan_ctrl #(
  parameter int DATA_W         = 4,
  parameter int ADDR_W         = 5,
  parameter int SCAN_DIV       = 50_000_000,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              scan_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_addr_q,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  clr_addr;
  logic [ADDR_W-1:0]  scan_addr;
  logic [DIV_W-1:0]   div_cnt;
  logic [ADDR_W-1:0]  eff_addr;
  logic               run;

  assign run      = (state == S_RUN);
  assign busy     = (state == S_CLEAR);
  assign eff_addr = scan_en ? scan_addr : rd_addr;

  // State register; reset re-enters the clear sweep when enabled.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    else          state <= state_nxt;
  end

  // Next-state: leave CLEAR after the last address has been zeroed.
  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR && clr_addr == '1) state_nxt = S_RUN;
  end

  // Clear address walks 0..DEPTH-1 while clearing.
  always_ff @(posedge clk) begin
    if (!reset_n)     clr_addr <= '0;
    else if (busy)    clr_addr <= clr_addr + 1'b1;
  end

  // Storage: the clear sweep owns the write port; reset alone never writes.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (busy)       mem[clr_addr] <= '0;
      else if (wr_en) mem[wr_addr]  <= wr_data;
    end
  end

  // Scan divider and address; held at zero until the clear finishes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      scan_addr <= '0;
    end else if (run) begin
      if (!scan_en) begin
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt   <= '0;
        scan_addr <= scan_addr + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Registered read, write-first on a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      rd_data   <= '0;
      rd_addr_q <= '0;
    end else begin
      rd_data   <= (wr_en && wr_addr == eff_addr) ? wr_data : mem[eff_addr];
      rd_addr_q <= eff_addr;
    end
  end

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Bench for ram_scan_ctrl: directed scenarios plus a random phase, all
// checked against a cycle-level behavioural model of the memory.
module tb_ram_scan_ctrl;

  localparam int DW = 4, AW = 5, DIV = 4, DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          scan_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] rd_addr_q;
  logic          busy;

  int n_cmp = 0, n_err = 0;

  // reference model state
  int m_mem [DEPTH];
  int m_cleared;      // words zeroed so far in the current clear sweep
  bit m_busy = 1'b1;
  int m_scan, m_ticks;
  int m_rd, m_q;

  ram_scan_ctrl #(.DATA_W(DW), .ADDR_W(AW), .SCAN_DIV(DIV), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .scan_en(scan_en),
    .rd_data(rd_data), .rd_addr_q(rd_addr_q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    int eff;
    if (!reset_n) begin
      m_busy = 1'b1; m_cleared = 0; m_scan = 0; m_ticks = 0; m_rd = 0; m_q = 0;
    end else if (m_busy) begin
      m_mem[m_cleared] = 0;
      m_cleared++;
      if (m_cleared == DEPTH) m_busy = 1'b0;
      m_rd = 0; m_q = 0;
    end else begin
      eff  = scan_en ? m_scan : int'(rd_addr);
      m_rd = (wr_en && int'(wr_addr) == eff) ? int'(wr_data) : m_mem[eff];
      m_q  = eff;
      if (wr_en) m_mem[wr_addr] = int'(wr_data);
      if (scan_en) begin
        m_ticks++;
        if (m_ticks == DIV) begin m_ticks = 0; m_scan = (m_scan + 1) % DEPTH; end
      end else m_ticks = 0;
    end
  endtask

  // One cycle: edge, model update, then compare away from the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("rd_addr_q", 32'(rd_addr_q), 32'(m_q));
    chk("busy", 32'(busy), 32'(m_busy));
  endtask

  // Release reset and count edges until busy drops (bounded).
  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin step(); n++; end
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

    // reset then clear, with a write attempted during the clear
    reset_n = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rd", 32'(rd_data), 32'd0);
    reset_n = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 4'hF;
    wait_clear("clr_len");
    wr_en = 1'b0; rd_addr = 5'd3;
    step();
    chk("clr_drop", 32'(rd_data), 32'd0);

    // basic write/read
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 4'hF; step();
    wr_addr = 5'd1; wr_data = 4'hD; step();
    wr_en = 1'b0; rd_addr = 5'd0; step();
    chk("rd0", 32'(rd_data), 32'hF);
    rd_addr = 5'd1; step();
    chk("rd1", 32'(rd_data), 32'hD);
    chk("rd1_q", 32'(rd_addr_q), 32'd1);

    // read-during-write, same address
    rd_addr = 5'd5; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 4'hA; step();
    chk("rdw", 32'(rd_data), 32'hA);

    // fill mem[i] = i[3:0], then scan across the wrap
    for (int i = 0; i < DEPTH; i++) begin
      wr_addr = AW'(i); wr_data = DW'(i); step();
    end
    wr_en = 1'b0; scan_en = 1'b1;
    for (int j = 0; j < 140; j++) begin
      step();
      chk("scan_q", 32'(rd_addr_q), 32'((j / DIV) % DEPTH));
      chk("scan_d", 32'(rd_data), 32'(((j / DIV) % DEPTH) & 15));
    end

    // pause at scan address 7, then resume
    for (int k = 0; k < 200 && m_scan != 7; k++) step();
    scan_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rd_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
      chk("pause_q", 32'(rd_addr_q), 32'(rd_addr));
    end
    scan_en = 1'b1;
    for (int k = 0; k < 4; k++) begin step(); chk("resume7", 32'(rd_addr_q), 32'd7); end
    step();
    chk("resume8", 32'(rd_addr_q), 32'd8);

    // reset mid-scan at address 20
    for (int k = 0; k < 200 && m_scan != 20; k++) step();
    reset_n = 1'b0; step();
    chk("mid_rst_busy", 32'(busy), 32'd1);
    reset_n = 1'b1;
    wait_clear("reclr_len");
    for (int j = 0; j < 12; j++) begin
      step();
      chk("rescan_q", 32'(rd_addr_q), 32'(j / DIV));
      chk("rescan_d", 32'(rd_data), 32'd0);
    end

    // random traffic with occasional resets
    for (int j = 0; j < 600; j++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      if ($urandom_range(0, 15) == 0) scan_en = ~scan_en;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
